// File: rtl/rr_merge_queue.sv
// Round-robin merge of p_num_inputs val/rdy streams into one stream through a
// 2-entry registered buffer, so out_rdy never reaches in_rdy combinationally.
module rr_merge_queue #(
    parameter int p_data_width = 32,
    parameter int p_num_inputs = 4,
    parameter int p_src_bits   = ($clog2(p_num_inputs) > 1) ? $clog2(p_num_inputs) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [p_num_inputs-1:0]              in_val,
    output logic [p_num_inputs-1:0]              in_rdy,
    input  logic [p_num_inputs*p_data_width-1:0] in_msg,
    output logic                                 out_val,
    input  logic                                 out_rdy,
    output logic [p_data_width-1:0]              out_msg,
    output logic [p_src_bits-1:0]                out_src
);

    localparam logic [p_src_bits:0]   LP_N_EXT = (p_src_bits + 1)'(p_num_inputs);
    localparam logic [p_src_bits-1:0] LP_LAST  = p_src_bits'(p_num_inputs - 1);

    logic [p_src_bits-1:0]   ptr_q, ptr_d;
    logic [p_data_width-1:0] msg_q [2];
    logic [p_data_width-1:0] msg_d [2];
    logic [p_src_bits-1:0]   src_q [2];
    logic [p_src_bits-1:0]   src_d [2];
    logic                    head_q, head_d;
    logic                    tail_q, tail_d;
    logic [1:0]              count_q, count_d;

    logic [p_num_inputs-1:0] grant_s;
    logic [p_src_bits-1:0]   gnt_idx_s;
    logic [p_data_width-1:0] gnt_msg_s;
    logic                    enq_ok_s;
    logic                    w_go_s;
    logic                    r_go_s;

    // Round-robin scan starting at ptr; the modulo wrap is explicit so any channel count works.
    always_comb begin : arb
        logic [p_src_bits:0] scan_v;
        logic                found_v;
        grant_s   = {p_num_inputs{1'b0}};
        gnt_idx_s = {p_src_bits{1'b0}};
        found_v   = 1'b0;
        scan_v    = {(p_src_bits + 1){1'b0}};
        for (int k = 0; k < p_num_inputs; k++) begin
            scan_v = {1'b0, ptr_q} + (p_src_bits + 1)'(k);
            if (scan_v >= LP_N_EXT) begin
                scan_v = scan_v - LP_N_EXT;
            end else begin
                scan_v = scan_v;
            end
            if (!found_v && in_val[scan_v[p_src_bits-1:0]]) begin
                found_v                              = 1'b1;
                grant_s[scan_v[p_src_bits-1:0]]      = 1'b1;
                gnt_idx_s                            = scan_v[p_src_bits-1:0];
            end else begin
                found_v = found_v;
            end
        end
    end

    // One-hot AND-OR select of the granted channel's message.
    always_comb begin
        gnt_msg_s = {p_data_width{1'b0}};
        for (int i = 0; i < p_num_inputs; i++) begin
            gnt_msg_s = gnt_msg_s | (in_msg[i*p_data_width +: p_data_width] & {p_data_width{grant_s[i]}});
        end
    end

    // Handshake qualification and reset-gated outputs.
    always_comb begin
        enq_ok_s = ~reset & (count_q != 2'd2);
        in_rdy   = grant_s & {p_num_inputs{enq_ok_s}};
        w_go_s   = |(in_val & in_rdy);
        out_val  = ~reset & (count_q != 2'd0);
        r_go_s   = out_val & out_rdy;
        if (reset) begin
            out_msg = {p_data_width{1'b0}};
            out_src = {p_src_bits{1'b0}};
        end else begin
            out_msg = msg_q[head_q];
            out_src = src_q[head_q];
        end
    end

    // Next-state for the buffer, its pointers and the priority pointer.
    always_comb begin
        ptr_d  = ptr_q;
        msg_d  = msg_q;
        src_d  = src_q;
        head_d = head_q;
        tail_d = tail_q;
        if (w_go_s) begin
            msg_d[tail_q] = gnt_msg_s;
            src_d[tail_q] = gnt_idx_s;
            tail_d        = ~tail_q;
            ptr_d         = (gnt_idx_s == LP_LAST) ? {p_src_bits{1'b0}} : gnt_idx_s + p_src_bits'(1);
        end else begin
            tail_d = tail_q;
        end
        if (r_go_s) begin
            head_d = ~head_q;
        end else begin
            head_d = head_q;
        end
        case ({w_go_s, r_go_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= {p_src_bits{1'b0}};
            msg_q[0] <= {p_data_width{1'b0}};
            msg_q[1] <= {p_data_width{1'b0}};
            src_q[0] <= {p_src_bits{1'b0}};
            src_q[1] <= {p_src_bits{1'b0}};
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            ptr_q    <= ptr_d;
            msg_q[0] <= msg_d[0];
            msg_q[1] <= msg_d[1];
            src_q[0] <= src_d[0];
            src_q[1] <= src_d[1];
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_rr_merge_queue.sv
// Bench for rr_merge_queue: directed scenarios plus randomized traffic, checked
// against a queue-based model of the buffer, round-robin rule and per-channel order.
module tb_rr_merge_queue;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int NB = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   in_val;
    logic [N-1:0]   in_rdy;
    logic [N*W-1:0] in_msg;
    logic           out_val;
    logic           out_rdy;
    logic [W-1:0]   out_msg;
    logic [1:0]     out_src;
    logic [W-1:0]   cur_msg [N];

    logic [NB-1:0]   in_val_b;
    logic [NB-1:0]   in_rdy_b;
    logic [NB*W-1:0] in_msg_b;
    logic            out_val_b;
    logic            out_rdy_b;
    logic [W-1:0]    out_msg_b;
    logic [1:0]      out_src_b;

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] mq_msg [$];
    int           mq_src [$];
    int           rptr;
    logic [W-1:0] ch_data [N][8];
    int           ch_wp [N];
    int           ch_rp [N];
    int           fair_wait [N];
    logic [W-1:0] hs_msg [$];
    int           hs_src [$];
    int           dut_hs;
    int           base_hs;

    rr_merge_queue #(.p_data_width(W), .p_num_inputs(N)) dut_a (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_src(out_src)
    );

    rr_merge_queue #(.p_data_width(W), .p_num_inputs(NB)) dut_b (
        .clk(clk), .reset(reset), .in_val(in_val_b), .in_rdy(in_rdy_b), .in_msg(in_msg_b),
        .out_val(out_val_b), .out_rdy(out_rdy_b), .out_msg(out_msg_b), .out_src(out_src_b)
    );

    always #5 clk = ~clk;

    always_comb begin
        in_msg = '0;
        for (int i = 0; i < N; i++) begin
            in_msg[i*W +: W] = cur_msg[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs at negedge against the model, then advance the model.
    task automatic step();
        int           g;
        int           d_src;
        logic         d_hs;
        logic         sv_rst;
        logic         sv_deq;
        logic [N-1:0] sv_val;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        sv_rst = reset;
        sv_val = in_val;
        g = -1;
        if (!reset && mq_msg.size() < 2) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && in_val[(rptr + k) % N]) g = (rptr + k) % N;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
        chk("out_val", 64'(out_val), 64'(!reset && mq_msg.size() > 0));
        if (reset) begin
            chk("rst_msg", 64'(out_msg), 64'(0));
            chk("rst_src", 64'(out_src), 64'(0));
        end else if (mq_msg.size() > 0) begin
            chk("out_msg", 64'(out_msg), 64'(mq_msg[0]));
            chk("out_src", 64'(out_src), 64'(mq_src[0]));
        end
        sv_deq = !reset && mq_msg.size() > 0 && out_rdy;
        d_hs   = !reset && out_val && out_rdy;
        d_src  = int'(out_src);
        if (d_hs) begin
            dut_hs++;
            hs_msg.push_back(out_msg);
            hs_src.push_back(d_src);
            if (d_src < N && ch_wp[d_src] != ch_rp[d_src])
                chk("chan_order", 64'(out_msg), 64'(ch_data[d_src][ch_rp[d_src] % 8]));
            else
                chk("chan_spurious", 64'(out_val), 64'(0));
        end
        @(posedge clk);
        #1;
        if (sv_rst) begin
            mq_msg.delete();
            mq_src.delete();
            rptr = 0;
            for (int i = 0; i < N; i++) begin
                ch_wp[i] = 0; ch_rp[i] = 0; fair_wait[i] = 0;
            end
        end else begin
            if (sv_deq) begin
                void'(mq_msg.pop_front());
                void'(mq_src.pop_front());
            end
            if (d_hs && d_src < N && ch_wp[d_src] != ch_rp[d_src]) ch_rp[d_src]++;
            for (int i = 0; i < N; i++) begin
                if (!sv_val[i] || i == g) begin
                    fair_wait[i] = 0;
                end else if (g >= 0) begin
                    fair_wait[i]++;
                    chk("fair_wait", 64'(fair_wait[i] <= N - 1), 64'(1));
                end
            end
            if (g >= 0) begin
                mq_msg.push_back(cur_msg[g]);
                mq_src.push_back(g);
                ch_data[g][ch_wp[g] % 8] = cur_msg[g];
                ch_wp[g]++;
                cur_msg[g] = cur_msg[g] + 32'd1;
                rptr = (g + 1) % N;
            end
        end
    endtask

    initial begin
        logic [NB-1:0] t4_rdy [4];
        int            t4_src [4];
        t4_rdy = '{3'b010, 3'b100, 3'b010, 3'b100};
        t4_src = '{1, 2, 1, 2};
        in_val = '0;
        out_rdy = 1'b0;
        in_val_b = '0;
        out_rdy_b = 1'b0;
        in_msg_b = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
        rptr = 0;
        dut_hs = 0;
        for (int i = 0; i < N; i++) begin
            cur_msg[i] = {8'(i), 24'h0};
            ch_wp[i] = 0; ch_rp[i] = 0; fair_wait[i] = 0;
        end

        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // All channels valid: strict rotation.
        hs_src.delete(); hs_msg.delete();
        in_val = 4'hF; out_rdy = 1'b1;
        repeat (9) step();
        chk("t1_cnt", 64'(hs_src.size()), 64'(8));
        for (int k = 0; k < 8; k++) begin
            if (k < hs_src.size()) chk("t1_src", 64'(hs_src[k]), 64'(k % 4));
        end
        in_val = '0;
        repeat (3) step();

        // Single requester, back-to-back.
        hs_src.delete(); hs_msg.delete();
        cur_msg[2] = 32'hA0;
        in_val = 4'b0100;
        repeat (5) step();
        in_val = '0;
        repeat (3) step();
        chk("t2_cnt", 64'(hs_src.size()), 64'(5));
        for (int k = 0; k < 5; k++) begin
            if (k < hs_src.size()) begin
                chk("t2_msg", 64'(hs_msg[k]), 64'(32'hA0 + k));
                chk("t2_src", 64'(hs_src[k]), 64'(2));
            end
        end

        // Fill to two entries with out_rdy low; in_rdy must not follow out_rdy.
        hs_src.delete(); hs_msg.delete();
        out_rdy = 1'b0; in_val = 4'b0011;
        repeat (3) step();
        out_rdy = 1'b1;
        #1;
        chk("t3_full_rdy", 64'(in_rdy), 64'(0));
        step();
        #1;
        chk("t3_rdy_back", 64'(in_rdy), 64'(4'b0001));
        repeat (2) step();
        in_val = '0;
        repeat (3) step();
        if (hs_src.size() >= 2) begin
            chk("t3_first", 64'(hs_src[0]), 64'(0));
            chk("t3_second", 64'(hs_src[1]), 64'(1));
        end else begin
            chk("t3_hs_cnt", 64'(hs_src.size()), 64'(2));
        end

        // Three-channel instance: 1,2 alternate and the pointer wraps 2 -> 0.
        in_val_b = 3'b110; out_rdy_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_rdy", 64'(in_rdy_b), 64'(t4_rdy[k]));
            if (k >= 1) begin
                chk("t4_val", 64'(out_val_b), 64'(1));
                chk("t4_src", 64'(out_src_b), 64'(t4_src[k-1]));
            end
            step();
        end
        #1;
        chk("t4_src_last", 64'(out_src_b), 64'(2));
        in_val_b = '0;

        // Reset with two entries buffered.
        out_rdy = 1'b0; in_val = 4'b0011;
        repeat (2) step();
        reset = 1'b1; out_rdy = 1'b1;
        #1;
        chk("t5_val_in_rst", 64'(out_val), 64'(0));
        chk("t5_rdy_in_rst", 64'(in_rdy), 64'(0));
        step();
        reset = 1'b0; in_val = '0;
        base_hs = dut_hs;
        repeat (3) step();
        chk("t5_no_stale", 64'(dut_hs - base_hs), 64'(0));

        // Randomized traffic with one mid-run reset.
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (in_val[i]) in_val[i] = ($urandom_range(0, 99) < 85);
                else           in_val[i] = ($urandom_range(0, 99) < 40);
            end
            out_rdy = ($urandom_range(0, 3) != 0);
            reset = (c == 5000);
            step();
        end
        reset = 1'b0; in_val = '0; out_rdy = 1'b1;
        repeat (4) step();
        for (int i = 0; i < N; i++) begin
            chk("drain_ch", 64'(ch_wp[i] - ch_rp[i]), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
